// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

    localparam int INSTR_W = 32;
    localparam int ADDR_W = 32;
    localparam logic [ADDR_W-1:0] PC_STEP = 32'd4;

    typedef enum logic {
        BOOT,
        RUN
    } state_e;

    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
    } entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of {pc, instr} entries between fetch and decode.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   push,
    input  logic   pop,
    input  logic   flush,
    input  entry_t tail,
    output logic   full,
    output logic   empty,
    output entry_t head
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] ONE = 1;

    logic [AW:0] wr_q, wr_d;
    logic [AW:0] rd_q, rd_d;
    entry_t      mem_q [DEPTH];
    logic        do_push;
    logic        do_pop;

    // Extra wrap bit distinguishes full from empty when indices match.
    assign empty = (wr_q == rd_q);
    assign full  = (wr_q[AW] != rd_q[AW]) &&
                   (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign head  = mem_q[rd_q[AW-1:0]];

    assign do_push = push & ~flush;
    assign do_pop  = pop & ~empty & ~flush;

    always_comb begin
        wr_d = wr_q;
        rd_d = rd_q;
        if (flush) begin
            wr_d = '0;
            rd_d = '0;
        end else begin
            if (do_push) wr_d = wr_q + ONE;
            if (do_pop)  rd_d = rd_q + ONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q[AW-1:0]] <= tail;
    end

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: PC register, boot FSM, stall counter and redirect priority.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000,
    parameter int                DEPTH    = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               fetch_en,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_data,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [ADDR_W-1:0]  out_pc,
    output logic [15:0]        stall_cycles
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [15:0]       stall_q, stall_d;

    logic   full;
    logic   empty;
    entry_t head;
    entry_t tail;
    logic   run;
    logic   pop;
    logic   fetch;
    logic   stall_inc;

    assign run       = (state_q == RUN);
    assign out_valid = ~empty;
    assign pop       = out_valid & out_ready;
    assign fetch     = run & fetch_en & ~redirect_valid & (~full | pop);
    assign stall_inc = run & fetch_en & ~redirect_valid & full & ~pop;

    assign tail         = '{pc: pc_q, instr: imem_data};
    assign imem_addr    = pc_q;
    assign stall_cycles = stall_q;
    assign out_instr    = out_valid ? head.instr : '0;
    assign out_pc       = out_valid ? head.pc : '0;

    // BOOT lasts exactly one clock so instruction memory can settle.
    always_comb begin
        state_d = RUN;
        pc_d    = pc_q;
        stall_d = stall_q;
        if (redirect_valid) begin
            pc_d = {redirect_pc[ADDR_W-1:2], 2'b00};
        end else if (fetch) begin
            pc_d = pc_q + PC_STEP;
        end
        if (stall_inc && stall_q != 16'hFFFF) begin
            stall_d = stall_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= BOOT;
            pc_q    <= RESET_PC;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            stall_q <= stall_d;
        end
    end

    fetch_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk  (clk),
        .rst  (rst),
        .push (fetch),
        .pop  (pop),
        .flush(redirect_valid),
        .tail (tail),
        .full (full),
        .empty(empty),
        .head (head)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: vector table, random model, corners.
module tb_fetch_unit;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fetch_en = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        out_ready = 1'b0;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        out_valid;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [15:0] stall_cycles;

    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] idx;
        idx = a >> 2;
        if (idx == 0) return 32'hA00000AA;
        return idx * 32'h10000011;
    endfunction

    assign imem_data = mem_word(imem_addr);

    fetch_unit #(
        .RESET_PC(32'h0),
        .DEPTH   (DEPTH)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .fetch_en      (fetch_en),
        .imem_addr     (imem_addr),
        .imem_data     (imem_data),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_instr     (out_instr),
        .out_pc        (out_pc),
        .stall_cycles  (stall_cycles)
    );

    task automatic check(input string nm, input logic [63:0] act,
                         input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        fetch_en = 1'b0;
        redirect_valid = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    typedef struct {
        logic        fe;
        logic        rdy;
        logic        rv;
        logic [31:0] rpc;
        logic        ev;
        logic [31:0] epc;
        logic [31:0] eaddr;
        logic [15:0] est;
    } vec_t;

    vec_t tbl[13];

    // Reference model state
    bit          m_booted;
    logic [31:0] m_pc;
    logic [63:0] m_q[$];
    int          m_stall;

    task automatic model_step(input logic fe, input logic rdy,
                              input logic rv, input logic [31:0] rpc);
        bit popped;
        if (rv) begin
            m_q.delete();
            m_pc = rpc & 32'hFFFF_FFFC;
            m_booted = 1;
        end else if (!m_booted) begin
            m_booted = 1;
        end else begin
            popped = (m_q.size() > 0) && rdy;
            if (popped) void'(m_q.pop_front());
            if (fe && m_q.size() < DEPTH) begin
                m_q.push_back({m_pc, mem_word(m_pc)});
                m_pc = m_pc + 32'd4;
            end else if (fe) begin
                if (m_stall < 16'hFFFF) m_stall++;
            end
        end
    endtask

    initial begin
        tbl[0]  = '{1, 0, 0, 32'h0,   0, 32'h0,  32'h0,   16'd0};
        tbl[1]  = '{1, 0, 0, 32'h0,   0, 32'h0,  32'h0,   16'd0};
        tbl[2]  = '{1, 0, 0, 32'h0,   1, 32'h0,  32'h4,   16'd0};
        tbl[3]  = '{1, 0, 0, 32'h0,   1, 32'h0,  32'h8,   16'd0};
        tbl[4]  = '{1, 0, 0, 32'h0,   1, 32'h0,  32'h8,   16'd1};
        tbl[5]  = '{1, 0, 0, 32'h0,   1, 32'h0,  32'h8,   16'd2};
        tbl[6]  = '{1, 1, 0, 32'h0,   1, 32'h0,  32'h8,   16'd3};
        tbl[7]  = '{1, 1, 0, 32'h0,   1, 32'h4,  32'hC,   16'd3};
        tbl[8]  = '{1, 0, 1, 32'h17,  1, 32'h8,  32'h10,  16'd3};
        tbl[9]  = '{1, 1, 0, 32'h0,   0, 32'h0,  32'h14,  16'd3};
        tbl[10] = '{1, 1, 1, 32'h100, 1, 32'h14, 32'h18,  16'd3};
        tbl[11] = '{1, 1, 0, 32'h0,   0, 32'h0,  32'h100, 16'd3};
        tbl[12] = '{1, 1, 0, 32'h0,   1, 32'h100, 32'h104, 16'd3};

        // Asynchronous reset values, before any clock edge
        #2;
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_addr", 64'(imem_addr), 64'd0);
        check("rst_stall", 64'(stall_cycles), 64'd0);
        check("rst_pc", 64'(out_pc), 64'd0);
        check("rst_instr", 64'(out_instr), 64'd0);

        do_reset();
        for (int i = 0; i < 13; i++) begin
            fetch_en = tbl[i].fe;
            out_ready = tbl[i].rdy;
            redirect_valid = tbl[i].rv;
            redirect_pc = tbl[i].rpc;
            check($sformatf("tbl%0d_valid", i), 64'(out_valid),
                  64'(tbl[i].ev));
            check($sformatf("tbl%0d_addr", i), 64'(imem_addr),
                  64'(tbl[i].eaddr));
            check($sformatf("tbl%0d_stall", i), 64'(stall_cycles),
                  64'(tbl[i].est));
            if (tbl[i].ev) begin
                check($sformatf("tbl%0d_pc", i), 64'(out_pc),
                      64'(tbl[i].epc));
                check($sformatf("tbl%0d_instr", i), 64'(out_instr),
                      64'(mem_word(tbl[i].epc)));
            end
            tick();
        end

        // Randomized run against the queue model
        do_reset();
        m_booted = 0;
        m_pc = 32'h0;
        m_q.delete();
        m_stall = 0;
        for (int c = 0; c < 3000; c++) begin
            fetch_en = ($urandom_range(0, 9) < 8);
            out_ready = ($urandom_range(0, 9) < 6);
            redirect_valid = ($urandom_range(0, 15) == 0);
            redirect_pc = ($urandom_range(0, 3) == 0)
                        ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                        : $urandom;
            check("rnd_valid", 64'(out_valid), 64'(m_q.size() > 0));
            check("rnd_addr", 64'(imem_addr), 64'(m_pc));
            check("rnd_stall", 64'(stall_cycles), 64'(m_stall));
            if (m_q.size() > 0)
                check("rnd_head", {out_pc, out_instr}, m_q[0]);
            model_step(fetch_en, out_ready, redirect_valid, redirect_pc);
            tick();
        end

        // PC wrap through the top of the address space
        fetch_en = 1'b1;
        out_ready = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 32'hFFFF_FFFF;
        tick();
        redirect_valid = 1'b0;
        check("wrap_valid0", 64'(out_valid), 64'd0);
        check("wrap_addr0", 64'(imem_addr), 64'hFFFF_FFFC);
        tick();
        check("wrap_pc0", 64'(out_pc), 64'hFFFF_FFFC);
        check("wrap_addr1", 64'(imem_addr), 64'h0);
        tick();
        check("wrap_pc1", 64'(out_pc), 64'h0);
        check("wrap_instr1", 64'(out_instr), 64'hA00000AA);

        // Build up stalls, then reset between edges
        out_ready = 1'b0;
        repeat (4) tick();
        check("pre_rst_stall", 64'(stall_cycles != 0), 64'd1);
        #2 rst = 1'b1;
        #1;
        check("arst_valid", 64'(out_valid), 64'd0);
        check("arst_addr", 64'(imem_addr), 64'd0);
        check("arst_stall", 64'(stall_cycles), 64'd0);
        #1 rst = 1'b0;
        out_ready = 1'b1;
        tick();
        check("boot_bubble", 64'(out_valid), 64'd0);
        tick();
        check("boot_valid", 64'(out_valid), 64'd1);
        check("boot_pc", 64'(out_pc), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage that owns the program counter, drives the instruction memory address, and buffers fetched words for decode. Sits directly upstream of `instrMem`, whose read is combinational from byte address to word. Each cycle it captures `{pc, instruction}` into a small FIFO and presents it to decode over a valid/ready handshake. Control flow changes arrive on a redirect port, which flushes the buffer and reloads the PC.

## Interface
Parameters:
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset. Must be word-aligned.
- `DEPTH`, default 2: FIFO entries. Must be a power of 2 and at least 2.

Ports:
- `clk`, input, 1: clock. All state changes on the rising edge.
- `rst`, input, 1: reset, asynchronous, active-high.
- `fetch_en`, input, 1: fetch permitted this cycle.
- `imem_addr`, output, 32: byte address to instruction memory. Always equal to the PC register.
- `imem_data`, input, 32: instruction word. Valid in the same cycle as `imem_addr`.
- `redirect_valid`, input, 1: load a new PC and flush the buffer.
- `redirect_pc`, input, 32: redirect target. Bits [1:0] are ignored and treated as 0.
- `out_valid`, output, 1: buffer head is valid.
- `out_ready`, input, 1: decode accepts the head this cycle.
- `out_instr`, output, 32: head instruction.
- `out_pc`, output, 32: byte address of the head instruction.
- `stall_cycles`, output, 16: saturating count of RUN cycles where `fetch_en`=1 but no fetch occurred because the FIFO was full.

## Operation
- FSM states:
  - BOOT: entered on reset. No fetch. Unconditionally moves to RUN after one clock, which lets instruction memory finish its reset-time load.
  - RUN: normal operation. Stays in RUN until `rst`.
- `pop` = `out_valid & out_ready`.
- `fetch` = RUN & `fetch_en` & !`redirect_valid` & (!full | `pop`).
- On `fetch`:
  - Write `{pc, imem_data}` to the FIFO tail.
  - Update `pc <= pc + 4`. Addition is modulo 2^32, so 32'hFFFF_FFFC wraps to 32'h0.
- Redirect has top priority in both BOOT and RUN:
  - FIFO is cleared, and any simultaneous pop or fetch is discarded.
  - `pc <= {redirect_pc[31:2], 2'b00}`.
  - `stall_cycles` is unaffected.
- Simultaneous push and pop while full is legal; occupancy stays unchanged. Push while empty has no bypass.
- `out_instr`/`out_pc` hold the head entry whenever `out_valid`=1. They are don't-care when `out_valid`=0.
- `stall_cycles` saturates at 16'hFFFF and never wraps.

## Timing
- Reset values, applied asynchronously:
  - state=BOOT, pc=`RESET_PC`, `imem_addr`=`RESET_PC`
  - FIFO empty, `out_valid`=0
  - `out_instr`=0, `out_pc`=0, `stall_cycles`=0
- First fetch happens at the second rising edge after `rst` falls. `out_valid` rises after that edge.
- Fetch-to-valid latency is 1 edge, from the write into an empty FIFO to `out_valid`=1.
- Redirect at edge E:
  - After E: `out_valid`=0 and `imem_addr`=target.
  - At E+1: the target entry is written, provided `fetch_en` is high and no new redirect arrives.
  - After E+1: `out_pc`=target.
- `rst` asserted mid-stream clears all state immediately, without waiting for a clock edge. In-flight entries are lost.
- Throughput is one instruction per cycle while `out_ready`=1 and `fetch_en`=1.

## Structure
- `fetch_pkg` contains:
  - `INSTR_W`=32, `ADDR_W`=32, `PC_STEP`=4
  - the FSM state enum {BOOT, RUN}
  - the packed entry type {pc[31:0], instr[31:0]}
- Sub-module `fetch_fifo` is a synchronous FIFO:
  - `DEPTH` entries, 64 bits wide.
  - Ports: push, pop, flush, full, empty, head.
  - flush takes priority over push and pop.
  - Read and write pointers carry one extra wrap bit.
- `fetch_unit` holds the PC register, the FSM, the stall counter and the priority logic.

## Test plan
- Reset release, streaming: with `fetch_en`=1, `out_ready`=1 and `instrMem` loaded, the outputs `(out_pc, out_instr)` must be (0, A00000AA), (4, 10000011), (8, 20000022) on consecutive cycles. The first valid appears 2 edges after `rst` falls.
- Backpressure: hold `out_ready`=0 for 5 cycles. The FIFO fills with PCs 0 and 4, and `pc` holds at 8. `stall_cycles` must equal 3. Raising `out_ready` then resumes in order 0, 4, 8.
- Redirect with a full buffer: assert `redirect_pc`=32'h17 while entries 0 and 4 are buffered. Next cycle `out_valid`=0. One cycle later, `out_pc`=32'h14 and `out_instr`=50000055.
- Simultaneous redirect and pop: assert `redirect_valid` together with `out_ready`=1. The popped entry counts as accepted, no stale entry appears afterwards, and the next `out_pc` equals the target.
- Wrap: redirect to 32'hFFFF_FFFC. The following `out_pc` sequence is FFFF_FFFC, then 0000_0000.
- Async reset mid-stream: pulse `rst` between clock edges. `out_valid`, `imem_addr` and `stall_cycles` go to 0 immediately, and the BOOT bubble repeats.
